rom_oscillator_iq_nco: RTL and testbench

//  Quadrature (cos/sin) NCO for runtime-programmable output frequency and phase.

---
 rtl/rom_oscillator_iq_nco.sv | 123 ++++++++++++
 tb/tb_rom_oscillator_iq_nco.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rom_oscillator_iq_nco.sv
// Quadrature (cos/sin) NCO: phase accumulator with runtime FTW and phase
// offset, quarter-wave sine LUT unfolded to a full turn by quadrant symmetry.
// Handshake: i_valid is a one-cycle sample strobe with no ready/backpressure;
// every i_valid produces exactly one o_valid three clocks later, gaps kept 1:1.
module rom_oscillator_iq_nco #(
  parameter int INT_DATA_WIDTH     = 20,
  parameter int INT_PHASE_WIDTH    = 32,
  parameter int INT_LUT_ADDR_WIDTH = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  input  logic        [INT_PHASE_WIDTH-1:0] i_ftw,
  input  logic                              i_ftw_load,
  input  logic        [INT_PHASE_WIDTH-1:0] i_phase_offset,
  input  logic                              i_phase_clear,
  output logic                              o_valid,
  output logic signed [INT_DATA_WIDTH-1:0]  o_cos,
  output logic signed [INT_DATA_WIDTH-1:0]  o_sin
);

  localparam int  W  = INT_DATA_WIDTH;
  localparam int  P  = INT_PHASE_WIDTH;
  localparam int  L  = INT_LUT_ADDR_WIDTH;
  localparam int  N  = 1 << L;
  localparam int  A  = (1 << (W - 1)) - 1;
  localparam real PI = 3.14159265358979323846;

  // Quarter-wave table sampled at half-step offsets so the table is symmetric
  // under a -> N-1-a; every entry lies in [0, A] so negation cannot overflow.
  logic [W-1:0] lut [N];
  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam real ANG = (real'(k) + 0.5) * PI / (2.0 * real'(N));
    assign lut[k] = W'($rtoi($sin(ANG) * real'(A) + 0.5));
  end

  logic [P-1:0] acc_q, acc_d;
  logic [P-1:0] ftw_q;
  logic [P-1:0] ph_q;
  logic         v1_q, v2_q, v3_q;
  logic [1:0]   quad_q;
  logic [W-1:0] mag_a_q, mag_b_q;
  logic [W-1:0] cos_q, cos_d, sin_q, sin_d;
  logic [L-1:0] addr_a, addr_b;

  // Accumulator next state: clear wins, otherwise advance on valid with the
  // FTW that was active before any same-cycle load.
  always_comb begin
    acc_d = acc_q;
    if (i_phase_clear)
      acc_d = '0;
    else if (i_valid)
      acc_d = acc_q + ftw_q;
  end

  // Accumulator and active tuning word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ftw_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (i_ftw_load)
        ftw_q <= i_ftw;
    end
  end

  // Fine phase bits below the LUT address are truncated.
  assign addr_a = ph_q[P-3 -: L];
  assign addr_b = ~addr_a;

  // S1: offset the pre-update phase. S2: quadrant and dual LUT read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q    <= '0;
      v1_q    <= 1'b0;
      quad_q  <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      ph_q    <= acc_q + i_phase_offset;
      v1_q    <= i_valid;
      quad_q  <= ph_q[P-1 -: 2];
      mag_a_q <= lut[addr_a];
      mag_b_q <= lut[addr_b];
      v2_q    <= v1_q;
    end
  end

  // S3 quadrant mapping: mag_a = sin of in-quadrant angle, mag_b = its cos.
  always_comb begin
    cos_d = mag_b_q;
    sin_d = mag_a_q;
    unique case (quad_q)
      2'd0: begin cos_d =  mag_b_q; sin_d =  mag_a_q; end
      2'd1: begin cos_d = -mag_a_q; sin_d =  mag_b_q; end
      2'd2: begin cos_d = -mag_b_q; sin_d = -mag_a_q; end
      2'd3: begin cos_d =  mag_a_q; sin_d = -mag_b_q; end
      default: ;
    endcase
  end

  // S3 output registers: samples update only on valid and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cos_q <= '0;
      sin_q <= '0;
      v3_q  <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        cos_q <= cos_d;
        sin_q <= sin_d;
      end
    end
  end

  assign o_valid = v3_q;
  assign o_cos   = $signed(cos_q);
  assign o_sin   = $signed(sin_q);

endmodule

// File: tb/tb_rom_oscillator_iq_nco.sv
// Bench for rom_oscillator_iq_nco: directed scenarios followed by random
// traffic, compared against a real-arithmetic model of the oscillator.
module tb_rom_oscillator_iq_nco;

  localparam int  W  = 20;
  localparam int  P  = 32;
  localparam int  L  = 10;
  localparam int  N  = 1 << L;
  localparam int  A  = (1 << (W - 1)) - 1;
  localparam real PI = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_valid;
  logic        [P-1:0] i_ftw;
  logic                i_ftw_load;
  logic        [P-1:0] i_phase_offset;
  logic                i_phase_clear;
  logic                o_valid;
  logic signed [W-1:0] o_cos;
  logic signed [W-1:0] o_sin;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit v;
    int c;
    int s;
  } smp_t;

  smp_t         exp_q[$];
  logic [P-1:0] m_acc;
  logic [P-1:0] m_ftw;
  int           h_cos;
  int           h_sin;

  rom_oscillator_iq_nco #(
    .INT_DATA_WIDTH(W), .INT_PHASE_WIDTH(P), .INT_LUT_ADDR_WIDTH(L)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ftw(i_ftw),
    .i_ftw_load(i_ftw_load), .i_phase_offset(i_phase_offset),
    .i_phase_clear(i_phase_clear), .o_valid(o_valid),
    .o_cos(o_cos), .o_sin(o_sin)
  );

  // clock
  always #5 clk = ~clk;

  // Round a [-1,1] value to the output scale, symmetric about zero.
  function automatic int quant(input real x);
    if (x >= 0.0) return $rtoi(x * real'(A) + 0.5);
    else          return -$rtoi(-x * real'(A) + 0.5);
  endfunction

  // Ideal cos/sin at the centre of the truncated phase bin (4N bins per turn).
  function automatic void ref_sample(input logic [P-1:0] ph, output int c, output int s);
    int  j;
    real th;
    j  = int'(ph >> (P - 2 - L));
    th = (real'(j) + 0.5) * 2.0 * PI / real'(4 * N);
    c  = quant($cos(th));
    s  = quant($sin(th));
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    smp_t z;
    z.v = 1'b0; z.c = 0; z.s = 0;
    m_acc = '0;
    m_ftw = '0;
    h_cos = 0;
    h_sin = 0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  // One clock of stimulus; model and checks run #1 after the edge.
  task automatic step(input bit v, input bit ld, input logic [P-1:0] ftw,
                      input logic [P-1:0] off, input bit clr);
    smp_t         e;
    logic [P-1:0] ph;
    i_valid        = v;
    i_ftw_load     = ld;
    i_ftw          = ftw;
    i_phase_offset = off;
    i_phase_clear  = clr;
    ph  = m_acc + off;
    e.v = v; e.c = 0; e.s = 0;
    if (v) ref_sample(ph, e.c, e.s);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (clr)    m_acc = '0;
    else if (v) m_acc = m_acc + m_ftw;
    if (ld)     m_ftw = ftw;
    e = exp_q.pop_front();
    if (e.v) begin
      h_cos = e.c;
      h_sin = e.s;
    end
    check("o_valid", int'(o_valid), int'(e.v));
    check("o_cos", int'(o_cos), h_cos);
    check("o_sin", int'(o_sin), h_sin);
  endtask

  initial begin
    logic [P-1:0] off_r;
    rst = 1'b1;
    i_valid = 1'b0; i_ftw = '0; i_ftw_load = 1'b0;
    i_phase_offset = '0; i_phase_clear = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_cos", int'(o_cos), 0);
    check("rst_sin", int'(o_sin), 0);
    #3 rst = 1'b0;

    // Single pulse with FTW=0: appears exactly three clocks later.
    step(1, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0);
    check("t1_cos", int'(o_cos), 524287);
    check("t1_sin", int'(o_sin), 402);
    step(0, 0, '0, '0, 0);

    // Quarter-turn steps.
    step(0, 1, 32'h4000_0000, '0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, '0, '0, 0);
    // Same with half-turn offset.
    step(0, 0, '0, 32'h8000_0000, 1);
    for (int i = 0; i < 10; i++) step(1, 0, '0, 32'h8000_0000, 0);
    // Negative frequency via wrap.
    step(0, 1, 32'hC000_0000, '0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, '0, '0, 0);

    // Load colliding with a valid step, then clear colliding with a valid.
    step(1, 1, 32'h1000_0000, '0, 0);
    step(1, 0, '0, '0, 0);
    step(1, 0, '0, '0, 1);
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0);
    check("clr_cos", int'(o_cos), 524287);

    // Async reset mid-stream with i_valid high.
    step(1, 1, 32'h0123_4567, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(o_valid), 0);
    check("arst_cos", int'(o_cos), 0);
    check("arst_sin", int'(o_sin), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    reset_model();
    for (int i = 0; i < 5; i++) step(1, 0, '0, '0, 0);

    // Random traffic.
    off_r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) off_r = $urandom;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, $urandom,
           off_r, $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, '0, off_r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
